mips_16_run_ctrl: RTL

//  Boot/run sequencer for mips_16_core_top. Streams a program into the instruction ROM over a

---
 rtl/mips_16_run_ctrl_if.sv | 24 ++
 rtl/mips_16_run_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mips_16_run_ctrl_if.sv
// Program-load stream and instruction-ROM write port of the mips_16 boot/run sequencer.
// The controller is the slave of the load stream and drives the ROM write strobe.
interface mips_16_run_ctrl_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   load_valid;
  logic                   load_ready;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;
  logic                   imem_we;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_16_run_ctrl.sv
// Boot/run sequencer for mips_16_core_top: streams a program into the instruction ROM,
// holds the core in reset while loading, then runs it until a PC halt or a cycle limit.
module mips_16_run_ctrl #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int RST_CYCLES  = 2,
  parameter int HALT_WINDOW = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  mips_16_run_ctrl_if.slave    bus,
  output logic                 o_core_rst,
  output logic                 o_core_hold,
  input  logic [PC_WIDTH-1:0]  i_core_pc,
  input  logic [CNT_WIDTH-1:0] i_run_limit,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_halted,
  output logic                 o_timeout,
  output logic [PC_WIDTH:0]    o_word_count,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RESET = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int HW = $clog2(HALT_WINDOW);

  logic [2:0]             r_state;
  logic [PC_WIDTH-1:0]    r_ptr;
  logic [PC_WIDTH:0]      r_word_cnt;
  logic [CNT_WIDTH-1:0]   r_cycle_cnt;
  logic [CNT_WIDTH-1:0]   r_limit;
  logic [RW-1:0]          r_rst_cnt;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [HW-1:0]          r_eq_cnt;
  logic                   r_first;
  logic                   r_halted;
  logic                   r_timeout;

  logic                   w_accept;
  logic                   w_full;
  logic                   w_rst_end;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   w_pc_same;
  logic [HW-1:0]          w_eq_next;
  logic                   w_halt;
  logic                   w_tmo;

  always_comb begin
    w_accept   = (r_state == S_LOAD) && bus.load_valid;
    w_full     = (r_ptr == '1);
    w_rst_end  = (r_rst_cnt == RW'(RST_CYCLES - 1));
    w_cnt_next = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + CNT_WIDTH'(1);
    // The first RUN cycle has no previous PC to compare against.
    w_pc_same  = !r_first && (i_core_pc == r_pc);
    w_eq_next  = w_pc_same ? r_eq_cnt + HW'(1) : '0;
    w_halt     = (r_state == S_RUN) && w_pc_same && (w_eq_next == HW'(HALT_WINDOW - 1));
    w_tmo      = (r_state == S_RUN) && (r_limit != '0) && (w_cnt_next == r_limit);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_word_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_limit     <= '0;
      r_rst_cnt   <= '0;
      r_pc        <= '0;
      r_eq_cnt    <= '0;
      r_first     <= 1'b1;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_LOAD;
            r_ptr       <= '0;
            r_word_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_ptr      <= r_ptr + PC_WIDTH'(1);
            r_word_cnt <= r_word_cnt + (PC_WIDTH+1)'(1);
            if (bus.load_last || w_full) begin
              r_state   <= S_RESET;
              r_rst_cnt <= '0;
            end
          end
        end
        S_RESET: begin
          if (w_rst_end) begin
            r_state     <= S_RUN;
            r_limit     <= i_run_limit;
            r_cycle_cnt <= '0;
            r_first     <= 1'b1;
            r_eq_cnt    <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
          end
        end
        S_RUN: begin
          r_cycle_cnt <= w_cnt_next;
          r_pc        <= i_core_pc;
          r_first     <= 1'b0;
          r_eq_cnt    <= w_eq_next;
          // Halt detection wins when both end conditions land on the same cycle.
          if (w_halt) begin
            r_state  <= S_DONE;
            r_halted <= 1'b1;
          end else if (w_tmo) begin
            r_state   <= S_DONE;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_core_rst     = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_RESET);
    o_core_hold    = (r_state == S_DONE);
    o_busy         = (r_state == S_LOAD) || (r_state == S_RESET) || (r_state == S_RUN);
    o_done         = (r_state == S_DONE);
    o_halted       = r_halted;
    o_timeout      = r_timeout;
    o_word_count   = r_word_cnt;
    o_cycle_count  = r_cycle_cnt;
    bus.load_ready = (r_state == S_LOAD);
    bus.imem_we    = w_accept;
    bus.imem_addr  = r_ptr;
    bus.imem_wdata = bus.load_data;
  end

endmodule
